// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: arbitration policy codes, output-stage states and index-width helper
package arb_mux_pkg;
  localparam int MODE_RR = 0;
  localparam int MODE_FIXED = 1;
  typedef enum logic {ST_EMPTY, ST_FULL} out_state_e;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/arb_mux_nto1_if.sv
// arb_mux_nto1_if: per-channel request bus plus the registered output handshake
interface arb_mux_nto1_if #(
  parameter int WIDTH = 8,
  parameter int NCH = 8,
  localparam int SELW = arb_mux_pkg::clog2_min1(NCH)
);
  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_ready;
  logic [NCH*WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0] out_sel;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sel);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sel);
endinterface

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin / fixed-priority grant via double-width masked priority encode
module rr_grant
  import arb_mux_pkg::*;
#(
  parameter int NCH = 8,
  parameter int MODE = MODE_RR,
  localparam int SELW = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt_onehot,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);
  localparam int PW = SELW + 1;
  logic [2*NCH-1:0] dbl;
  logic [PW-1:0] pos;
  // Lower copy masked below ptr; the first hit wraps into the upper copy when nothing at or above ptr requests
  always_comb begin
    dbl = {req, req};
    for (int j = 0; j < NCH; j++) dbl[j] = req[j] && (MODE == MODE_FIXED || j >= int'(ptr));
    pos = '0;
    for (int j = 2*NCH-1; j >= 0; j--) if (dbl[j]) pos = PW'(j);
  end
  assign gnt_idx = SELW'(pos >= PW'(NCH) ? pos - PW'(NCH) : pos);
  assign any = |req;
  assign gnt_onehot = any ? NCH'(1) << gnt_idx : '0;
endmodule

// File: rtl/arb_mux_nto1.sv
// arb_mux_nto1: N-to-1 arbitrated mux with a one-entry registered valid/ready output stage
module arb_mux_nto1
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH = 8,
  parameter int MODE = MODE_RR,
  localparam int SELW = clog2_min1(NCH)
) (
  input logic clk,
  input logic rst,
  arb_mux_nto1_if.slave bus
);
  out_state_e state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d, ptr_q, ptr_d, gnt_idx;
  logic [NCH-1:0] gnt_onehot;
  logic any, load, consume;
  rr_grant #(.NCH(NCH), .MODE(MODE)) u_grant (
    .req(bus.in_valid),
    .ptr(ptr_q),
    .gnt_onehot(gnt_onehot),
    .gnt_idx(gnt_idx),
    .any(any)
  );
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = load ? (any ? ST_FULL : ST_EMPTY) : state_q;
  end
  // No beat may be taken in a reset cycle, so the grant is gated by rst
  always_comb begin
    load = state_q == ST_EMPTY || bus.out_ready;
    consume = load && any && !rst;
    bus.in_ready = consume ? gnt_onehot : '0;
    bus.out_valid = state_q == ST_FULL;
  end
  always_comb begin
    data_d = consume ? bus.in_data[gnt_idx*WIDTH +: WIDTH] : data_q;
    sel_d = consume ? gnt_idx : sel_q;
    ptr_d = (MODE == MODE_RR && consume) ? (gnt_idx == SELW'(NCH-1) ? '0 : gnt_idx + SELW'(1)) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
    end else begin
      data_q <= data_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
    end
  end
  assign bus.out_data = data_q;
  assign bus.out_sel = sel_q;
endmodule

// File: tb/tb_arb_mux_nto1.sv
// tb_arb_mux_nto1: three configurations (RR/8, RR/5, fixed/8) checked by vectors, sequences and a queue-free scan model
module tb_arb_mux_nto1;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  v_in[3];
  logic [63:0] d_in[3];
  logic        ordy[3];
  logic        rst_in[3];
  int nch[3] = '{8, 5, 8};
  int mode[3] = '{0, 0, 1};
  logic [7:0] chan[8] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5, 8'h16, 8'h27};

  int checks = 0;
  int failures = 0;

  bit         m_v[3] = '{0, 0, 0};
  logic [7:0] m_d[3] = '{0, 0, 0};
  int         m_s[3] = '{0, 0, 0};
  int         m_ptr[3] = '{0, 0, 0};

  typedef struct {
    logic [7:0] valid;
    logic [7:0] exp_data;
    int         exp_sel;
  } vec_t;
  vec_t tbl[8];

  arb_mux_nto1_if #(.WIDTH(8), .NCH(8)) ia();
  arb_mux_nto1_if #(.WIDTH(8), .NCH(5)) ib();
  arb_mux_nto1_if #(.WIDTH(8), .NCH(8)) ic();

  assign ia.in_valid = v_in[0];
  assign ia.in_data = d_in[0];
  assign ia.out_ready = ordy[0];
  assign ib.in_valid = v_in[1][4:0];
  assign ib.in_data = d_in[1][39:0];
  assign ib.out_ready = ordy[1];
  assign ic.in_valid = v_in[2];
  assign ic.in_data = d_in[2];
  assign ic.out_ready = ordy[2];

  arb_mux_nto1 #(.WIDTH(8), .NCH(8), .MODE(0)) ua (.clk(clk), .rst(rst_in[0]), .bus(ia));
  arb_mux_nto1 #(.WIDTH(8), .NCH(5), .MODE(0)) ub (.clk(clk), .rst(rst_in[1]), .bus(ib));
  arb_mux_nto1 #(.WIDTH(8), .NCH(8), .MODE(1)) uc (.clk(clk), .rst(rst_in[2]), .bus(ic));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic rd(input int k, output logic [7:0] rdy, output logic ov, output logic [7:0] od, output int os);
    case (k)
      0: begin rdy = ia.in_ready; ov = ia.out_valid; od = ia.out_data; os = int'(ia.out_sel); end
      1: begin rdy = 8'(ib.in_ready); ov = ib.out_valid; od = ib.out_data; os = int'(ib.out_sel); end
      default: begin rdy = ic.in_ready; ov = ic.out_valid; od = ic.out_data; os = int'(ic.out_sel); end
    endcase
  endtask

  // Scan order starts at the pointer (or 0 for fixed priority) and wraps modulo the channel count
  function automatic int winner(input int k, input logic [7:0] v);
    int st;
    st = mode[k] == 1 ? 0 : m_ptr[k];
    for (int n = 0; n < nch[k]; n++) if (v[(st + n) % nch[k]]) return (st + n) % nch[k];
    return -1;
  endfunction

  task automatic cyc();
    bit n_v[3];
    logic [7:0] n_d[3];
    int n_s[3], n_p[3];
    logic [7:0] rdy, od, er;
    logic ov;
    int os, w;
    bit ld;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_v[k] = m_v[k]; n_d[k] = m_d[k]; n_s[k] = m_s[k]; n_p[k] = m_ptr[k];
      w = winner(k, v_in[k]);
      ld = !m_v[k] || ordy[k];
      er = (!rst_in[k] && ld && w >= 0) ? 8'(1 << w) : 8'h00;
      rd(k, rdy, ov, od, os);
      chk($sformatf("in_ready[%0d]", k), rdy, er);
      if (rst_in[k]) begin
        n_v[k] = 0; n_d[k] = 0; n_s[k] = 0; n_p[k] = 0;
      end else if (ld) begin
        n_v[k] = w >= 0;
        if (w >= 0) begin
          n_d[k] = d_in[k][w*8 +: 8];
          n_s[k] = w;
          if (mode[k] == 0) n_p[k] = (w + 1) % nch[k];
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      m_v[k] = n_v[k]; m_d[k] = n_d[k]; m_s[k] = n_s[k]; m_ptr[k] = n_p[k];
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rd(k, rdy, ov, od, os);
      chk($sformatf("model_valid[%0d]", k), ov, m_v[k]);
      chk($sformatf("model_data[%0d]", k), od, m_d[k]);
      chk($sformatf("model_sel[%0d]", k), os, m_s[k]);
    end
  endtask

  task automatic expect_out(input string nm, input int k, input logic v, input logic [7:0] d, input int s);
    logic [7:0] rdy, od;
    logic ov;
    int os;
    rd(k, rdy, ov, od, os);
    chk({nm, "_valid"}, ov, v);
    chk({nm, "_data"}, od, d);
    chk({nm, "_sel"}, os, s);
  endtask

  task automatic expect_ready(input string nm, input int k, input logic [7:0] r);
    logic [7:0] rdy, od;
    logic ov;
    int os;
    rd(k, rdy, ov, od, os);
    chk(nm, rdy, r);
  endtask

  task automatic rst_one(input int k);
    rst_in[k] = 1'b1;
    cyc();
    rst_in[k] = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'h01, 8'hA0, 0};
    tbl[1] = '{8'h02, 8'hB1, 1};
    tbl[2] = '{8'h04, 8'hC2, 2};
    tbl[3] = '{8'h08, 8'hD3, 3};
    tbl[4] = '{8'h10, 8'hE4, 4};
    tbl[5] = '{8'h20, 8'hF5, 5};
    tbl[6] = '{8'h40, 8'h16, 6};
    tbl[7] = '{8'h80, 8'h27, 7};
    for (int k = 0; k < 3; k++) begin
      v_in[k] = 8'hFF;
      d_in[k] = 64'h2716F5E4D3C2B1A0;
      ordy[k] = 1'b1;
      rst_in[k] = 1'b1;
    end
    cyc();
    cyc();
    for (int k = 0; k < 3; k++) begin
      expect_out($sformatf("reset%0d", k), k, 1'b0, 8'h00, 0);
      expect_ready($sformatf("reset_ready%0d", k), k, 8'h00);
      rst_in[k] = 1'b0;
      v_in[k] = 8'h00;
    end
    cyc();
    for (int k = 0; k < 3; k++) expect_out($sformatf("idle%0d", k), k, 1'b0, 8'h00, 0);

    for (int i = 0; i < 8; i++) begin
      v_in[0] = tbl[i].valid;
      cyc();
      expect_out($sformatf("single%0d", i), 0, 1'b1, tbl[i].exp_data, tbl[i].exp_sel);
    end
    v_in[0] = 8'h00;
    cyc();
    expect_out("drain", 0, 1'b0, 8'h27, 7);

    rst_one(0);
    v_in[0] = 8'hFF;
    for (int n = 0; n < 16; n++) begin
      cyc();
      expect_out($sformatf("fair%0d", n), 0, 1'b1, chan[n % 8], n % 8);
    end
    v_in[0] = 8'h00;

    rst_one(1);
    v_in[1] = 8'h11;
    for (int n = 0; n < 4; n++) begin
      cyc();
      expect_out($sformatf("wrap%0d", n), 1, 1'b1, chan[(n % 2) * 4], (n % 2) * 4);
    end
    v_in[1] = 8'h00;

    rst_one(0);
    v_in[0] = 8'h04;
    cyc();
    expect_out("bp_load", 0, 1'b1, 8'hC2, 2);
    ordy[0] = 1'b0;
    v_in[0] = 8'hFF;
    for (int n = 0; n < 3; n++) begin
      cyc();
      expect_out($sformatf("bp_hold%0d", n), 0, 1'b1, 8'hC2, 2);
      expect_ready($sformatf("bp_ready%0d", n), 0, 8'h00);
    end
    ordy[0] = 1'b1;
    v_in[0] = 8'h08;
    #1;
    expect_ready("bp_release_ready", 0, 8'h08);
    cyc();
    expect_out("bp_next", 0, 1'b1, 8'hD3, 3);
    v_in[0] = 8'h00;

    rst_one(2);
    v_in[2] = 8'h60;
    for (int n = 0; n < 4; n++) begin
      cyc();
      expect_out($sformatf("fixed%0d", n), 2, 1'b1, 8'hF5, 5);
    end
    rst_in[2] = 1'b1;
    cyc();
    expect_out("mid_reset", 2, 1'b0, 8'h00, 0);
    rst_in[2] = 1'b0;
    v_in[2] = 8'h00;
    cyc();

    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 3; k++) begin
        v_in[k] = 8'($urandom);
        d_in[k] = {$urandom, $urandom};
        ordy[k] = $urandom_range(0, 3) != 0;
        rst_in[k] = $urandom_range(0, 60) == 0;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arb_mux_nto1.md
Name: arb_mux_nto1

Overview:
- Parametrised successor to the combinational 8:1 byte mux.
- Selects one of NCH WIDTH-bit requesting channels per cycle under a round-robin or fixed-priority policy.
- Registers the winning beat into a one-entry output stage with a valid/ready handshake.
- Feeds the ALU operand/result path, where several producers share one consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 8, number of input channels (legal range 1..64; need not be a power of two).
- MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).
- SELW, (NCH>1 ? $clog2(NCH) : 1), derived width of the channel index; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  NCH  per-channel request; bit i belongs to channel i.
- in_data  input  NCH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  one-hot or zero; channel i's beat is consumed this cycle when in_valid[i] && in_ready[i].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  WIDTH  registered winning data.
- out_sel  output  SELW  registered index of the channel that supplied out_data.

Behaviour:
- Reset values (applied on the clk edge while rst=1):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready is combinational and is 0 while rst=1.
  - Reset during operation discards any held beat; no input beat is consumed in a reset cycle.
- Output stage is a 2-state FSM on out_valid:
  - EMPTY (out_valid=0): load = 1.
  - FULL (out_valid=1): load = out_ready.
  - Transitions: EMPTY->FULL on load with any in_valid; FULL->EMPTY on out_ready with no winner; FULL->FULL on out_ready with a winner (back-to-back, 1 beat/cycle); FULL holds when out_ready=0.
- Grant (combinational):
  - MODE=0: winner g is the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., NCH-1, 0, ..., rr_ptr-1.
  - MODE=1: winner g is the lowest i with in_valid[i]=1.
  - in_ready[g] = load; all other bits of in_ready are 0. in_ready is all-zero if no request.
- On a consume (load && any in_valid): out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- Pointer update:
  - MODE=0: rr_ptr <= (g==NCH-1) ? 0 : g+1, only on a consume.
  - MODE=1: rr_ptr is unused and stays 0.
- Stability:
  - While out_valid && !out_ready, out_data and out_sel hold and in_ready is all-zero (backpressure).
  - A requester may change or drop in_valid at any time; only consumed beats are recorded.
- Latency: a beat consumed at edge k is visible on out_* after edge k. Throughput is 1 beat/cycle with out_ready held high.
- Fairness (MODE=0): with all channels requesting continuously, each channel wins exactly once in every NCH consecutive consumes.
- NCH=1: grant is in_valid[0]; out_sel stays 0.

Decomposition:
- Package arb_mux_pkg:
  - localparams MODE_RR=0 and MODE_FIXED=1.
  - function clog2_min1(n), which returns SELW.
- Sub-module rr_grant (purely combinational):
  - Parameters NCH, MODE.
  - Inputs req[NCH], ptr[SELW].
  - Outputs gnt_onehot[NCH], gnt_idx[SELW], any.
  - Implemented with double-width masked priority encoding.
- The top level holds the output register, the FSM and rr_ptr.

Test Plan:
- Reset/idle: assert rst for 2 cycles with in_valid=8'hFF -> out_valid=0, out_data=0, out_sel=0, in_ready=0. Deassert rst with in_valid=0 -> out_valid stays 0.
- Single requester: channel data A0,B1,C2,D3,E4,F5,16,27 and out_ready=1; for each i=0..7, pulse in_valid bit i for one cycle -> next cycle out_valid=1, out_sel=i, out_data = channel i value (e.g. i=5 -> F5).
- Round-robin fairness: MODE=0, in_valid=8'hFF, out_ready=1 for 16 cycles -> out_sel sequence 0,1,...,7,0,...,7 with out_valid=1 every cycle after the first.
- Non-power-of-two wrap: NCH=5, in_valid=5'b10001 continuously -> out_sel alternates 0,4,0,4; rr_ptr wraps from 4 to 0.
- Backpressure: out_ready=0 for 3 cycles while FULL with out_data=C2 -> out_data and out_sel hold, in_ready=0. Raise out_ready with in_valid[3]=1 -> next beat is D3 with no cycle lost.
- Fixed priority and reset mid-operation: MODE=1, in_valid=8'b0110_0000 -> out_sel=5 repeatedly (no rotation). Assert rst while FULL -> next cycle out_valid=0 and the held beat is dropped.
